apb_regfile_ws: RTL and testbench
=================================

# apb_regfile_ws

Parametrised APB completer register file: NUM_REGS word-aligned 32-bit (default) registers behind an APB access state machine with configurable wait states, error response on bad or read-only accesses, and optional byte-strobe writes. It is the next-generation peripheral register block and attaches directly to an APB requester or interconnect port. It replaces fixed four-register, zero-wait, error-free slaves.

## Interface
- ADDR_WIDTH, 8, PADDR width in bits; must satisfy 2^ADDR_WIDTH >= 4*NUM_REGS.
- DATA_WIDTH, 32, register and bus data width; multiple of 8.
- NUM_REGS, 8, number of registers; 1..64.
- WAIT_STATES, 0, PREADY-low cycles inserted in every access phase; 0..15.
- RO_MASK, 0, NUM_REGS-bit mask; bit i set makes register i read-only.
- PCLK  in  1  clock, all logic on rising edge.
- PRESETn  in  1  reset; one clock, synchronous, active-low.
- PSEL  in  1  select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte strobes (present only with APB_REGFILE_PSTRB_EN).
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  transfer error, valid only while PREADY=1.

## Operation
- Register i occupies byte address 4*i.
- Decode error: PADDR[1:0] != 0, or PADDR>>2 >= NUM_REGS.
- Write error: write to a register whose RO_MASK bit is set.
- An erroring transfer completes normally with PSLVERR=1 and changes no register.
- FSM states:
  - IDLE: on PSEL=1 and PENABLE=0 at a clock edge, load wait counter with WAIT_STATES and go to ACCESS.
  - ACCESS, counter != 0: PREADY=0; counter decrements each cycle.
  - ACCESS, counter = 0: PREADY=1; at the next edge the transfer completes, a valid write commits, and the FSM returns to IDLE.
- PSEL=0 while in ACCESS: abort to IDLE at that edge; no write; PREADY stays 0.
- PENABLE=0 while in ACCESS with PSEL=1 is a protocol violation: hold the counter; no commit until PENABLE=1.
- PADDR, PWRITE and PWDATA are sampled at the completing edge; the requester must hold them stable per APB.
- Read data:
  - PRDATA = selected register when in ACCESS with PREADY=1, PWRITE=0 and no decode error.
  - PRDATA = 0 otherwise, including error reads.
- Reading a read-only register is legal and returns its contents, which stay 0 from reset because no bus write can change them.

## Timing
- Reset (PRESETn=0 at an edge): all registers 0, FSM IDLE, counter 0. PREADY=0, PSLVERR=0, PRDATA=0 from the following cycle.
- Reset mid-transfer aborts the transfer; the write is not committed.
- Setup phase lasts 1 cycle. Access phase lasts WAIT_STATES+1 cycles. Total transfer is WAIT_STATES+2 cycles.
- PREADY, PSLVERR and PRDATA are combinational from FSM state, counter and the APB inputs. No output depends on its own value.
- Write data is visible to a read whose access phase starts after the completing edge.
- Back-to-back transfers: IDLE is re-entered at completion. A new setup phase can be sampled in the cycle immediately after the completing edge, so there are no dead cycles.

## Configuration
- APB_REGFILE_PSTRB_EN defined:
  - PSTRB port present.
  - On a committed write, byte b of the register updates only if PSTRB[b]=1.
  - PSTRB=0 on a write is legal, completes without error and changes nothing.
  - PSTRB is ignored on reads.
- APB_REGFILE_PSTRB_EN undefined: no PSTRB port; every committed write updates the full word.

## Test plan
- Reset, WAIT_STATES=0: write 0xDEADBEEF to 0x04, read 0x04.
  - Each transfer is 2 cycles with PREADY=1 in the second.
  - Read returns 0xDEADBEEF with PSLVERR=0.
  - Read of 0x08 returns 0.
- WAIT_STATES=3: read 0x00.
  - PREADY is 0 for 3 access cycles, then 1.
  - PRDATA=0 until PREADY=1.
  - Transfer takes 5 cycles total.
- Error cases, each with PSLVERR=1, PREADY=1 and no register change:
  - Write to 0x02 (misaligned).
  - Write to 4*NUM_REGS (out of range).
  - Write to a RO_MASK register.
- Abort and reset:
  - WAIT_STATES=2, write 0x55 to 0x0C, drop PSEL after 1 access cycle: register stays 0 and the FSM is IDLE.
  - Separately, assert PRESETn=0 mid-access: all outputs 0 and registers 0.
- PSTRB_EN: write 0xAABBCCDD to 0x00, then write 0x11223344 with PSTRB=0b0101; read returns 0xAA22CC44.
- Back-to-back: write 0x1 to 0x10, then read 0x10 in the very next setup cycle; read returns 0x1 with no idle cycle between transfers.

Source files
------------

// File: rtl/apb_regfile_ws.sv
// APB completer register file with programmable wait states and PSLVERR on bad or read-only accesses.
// Define APB_REGFILE_PSTRB_EN to add the PSTRB port and byte-masked writes.
module apb_regfile_ws #(
    parameter int                   ADDR_WIDTH  = 8,
    parameter int                   DATA_WIDTH  = 32,
    parameter int                   NUM_REGS    = 8,
    parameter int                   WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_REGFILE_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int IW = ADDR_WIDTH - 2;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]            state_q;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic [IW-1:0]         idx;
    logic                  dec_err;
    logic                  ro_hit;
    logic                  complete;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] wmask;

    assign idx     = PADDR[ADDR_WIDTH-1:2];
    assign dec_err = (PADDR[1:0] != 2'b00) || (32'(idx) >= NUM_REGS);

    // NOTE: every always_comb output gets a default before the loop, so no path can infer a latch.
    always_comb begin
        ro_hit   = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IW'(i)) begin
                ro_hit   = RO_MASK[i];
                sel_data = regs_q[i];
            end
        end
    end

`ifdef APB_REGFILE_PSTRB_EN
    always_comb begin
        wmask = '0;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            wmask[8*b +: 8] = {8{PSTRB[b]}};
        end
    end
`else
    assign wmask = '1;
`endif

    // Completion is gated by PSEL/PENABLE so an aborted or stalled access never shows PREADY.
    assign complete = (state_q == ST_ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
    assign PREADY   = complete;
    assign PSLVERR  = complete && (dec_err || (PWRITE && ro_hit));
    assign PRDATA   = (complete && !PWRITE && !dec_err) ? sel_data : '0;
    assign wr_en    = complete && PWRITE && !dec_err && !ro_hit;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state_q <= ST_ACCESS;
                        cnt_q   <= 4'(WAIT_STATES);
                    end
                end
                default: begin
                    if (!PSEL) begin
                        state_q <= ST_IDLE;
                    end else if (PENABLE) begin
                        if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                        else               state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // NOTE: the register array is built from flops, not a RAM macro, so it can and must be cleared on reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx == IW'(i) && !RO_MASK[i]) begin
                    regs_q[i] <= (regs_q[i] & ~wmask) | (PWDATA & wmask);
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_ws.sv
// Self-checking bench for apb_regfile_ws: two instances (0 and 3 wait states) against a transfer-level model.
`timescale 1ns/1ps
module tb_apb_regfile_ws;

    localparam int             NR  = 8;
    localparam int             WS0 = 0;
    localparam int             WS1 = 3;
    localparam logic [NR-1:0]  RO0 = 8'h80;
    localparam logic [NR-1:0]  RO1 = 8'h04;

    logic PCLK = 1'b0;
    logic PRESETn;
    always #5 PCLK = ~PCLK;

    logic        psel[2], penable[2], pwrite[2];
    logic [7:0]  paddr[2];
    logic [31:0] pwdata[2];
`ifdef APB_REGFILE_PSTRB_EN
    logic [3:0]  pstrb[2];
`endif
    logic [31:0] prdata[2];
    logic        pready[2], pslverr[2];

    int            ws_of[2];
    logic [NR-1:0] ro_of[2];
    logic [31:0]   mem[2][NR];

    logic        chk_on = 1'b0;
    logic        exp_ready[2], exp_err[2];
    logic [31:0] exp_rdata[2];
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          allow_hold = 1'b0;

    apb_regfile_ws #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(NR), .WAIT_STATES(WS0), .RO_MASK(RO0)) u_dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
        .PADDR(paddr[0]), .PWDATA(pwdata[0]),
`ifdef APB_REGFILE_PSTRB_EN
        .PSTRB(pstrb[0]),
`endif
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_regfile_ws #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(NR), .WAIT_STATES(WS1), .RO_MASK(RO1)) u_dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
        .PADDR(paddr[1]), .PWDATA(pwdata[1]),
`ifdef APB_REGFILE_PSTRB_EN
        .PSTRB(pstrb[1]),
`endif
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge PCLK) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("dut%0d PREADY", d),  32'(pready[d]),  32'(exp_ready[d]));
                check($sformatf("dut%0d PSLVERR", d), 32'(pslverr[d]), 32'(exp_err[d]));
                check($sformatf("dut%0d PRDATA", d),  prdata[d],       exp_rdata[d]);
            end
        end
    end

    function automatic bit m_dec_err(input logic [7:0] a);
        return (a[1:0] != 2'b00) || (int'(a >> 2) >= NR);
    endfunction

    function automatic bit m_err(input int d, input bit wr, input logic [7:0] a);
        if (m_dec_err(a)) return 1'b1;
        return wr && ro_of[d][a >> 2];
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NR; i++) mem[d][i] = 32'h0;
    endtask

    task automatic set_exp(input int d, input logic r, input logic e, input logic [31:0] rd);
        exp_ready[d] = r;
        exp_err[d]   = e;
        exp_rdata[d] = rd;
    endtask

    task automatic go_idle(input int d);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        set_exp(d, 1'b0, 1'b0, 32'h0);
    endtask

    // One APB transfer starting just after a rising edge; abort_at/rst_at name the access cycle to disturb (-1 = none).
    task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input int abort_at, input int rst_at,
                        output logic [31:0] rd, output bit err, output int ncyc);
        int          k;
        bit          e;
        logic [31:0] er;
`ifndef APB_REGFILE_PSTRB_EN
        st = 4'hF;
`endif
        e  = m_err(d, wr, a);
        er = (!wr && !m_dec_err(a)) ? mem[d][a >> 2] : 32'h0;
        rd = 32'h0; err = 1'b0; ncyc = 1; k = 0;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
`ifdef APB_REGFILE_PSTRB_EN
        pstrb[d] = st;
`endif
        set_exp(d, 1'b0, 1'b0, 32'h0);
        forever begin
            @(posedge PCLK); #1;
            if (allow_hold && $urandom_range(0, 5) == 0) begin
                penable[d] = 1'b0;
                set_exp(d, 1'b0, 1'b0, 32'h0);
                continue;
            end
            penable[d] = 1'b1;
            ncyc++;
            if (k == abort_at) begin
                go_idle(d);
                @(posedge PCLK); #1;
                return;
            end
            if (k == ws_of[d]) set_exp(d, 1'b1, e, er);
            else               set_exp(d, 1'b0, 1'b0, 32'h0);
            if (k == rst_at) begin
                PRESETn = 1'b0;
                @(posedge PCLK); #1;
                PRESETn = 1'b1;
                clear_model();
                set_exp(d, 1'b0, 1'b0, 32'h0);
                @(posedge PCLK); #1;
                go_idle(d);
                return;
            end
            if (k == ws_of[d]) begin
                @(negedge PCLK);
                rd  = prdata[d];
                err = pslverr[d];
                @(posedge PCLK); #1;
                if (wr && !e)
                    for (int b = 0; b < 4; b++)
                        if (st[b]) mem[d][a >> 2][8*b +: 8] = wd[8*b +: 8];
                go_idle(d);
                return;
            end
            k++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          err;
        int          nc, nc2;
        int          d, ab;
        bit          wr;
        logic [7:0]  a;

        ws_of[0] = WS0; ws_of[1] = WS1;
        ro_of[0] = RO0; ro_of[1] = RO1;
        clear_model();
        for (int i = 0; i < 2; i++) begin
            pwrite[i] = 1'b0; paddr[i] = 8'h0; pwdata[i] = 32'h0;
`ifdef APB_REGFILE_PSTRB_EN
            pstrb[i] = 4'h0;
`endif
            go_idle(i);
        end
        PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        chk_on = 1'b1;
        @(negedge PCLK);
        check("reset PREADY", 32'(pready[0]), 32'h0);
        check("reset PRDATA", prdata[1], 32'h0);
        @(posedge PCLK); #1;

        // Zero wait states: write then read back
        xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, -1, -1, rd, err, nc);
        check("ws0 write cycles", 32'(nc), 32'd2);
        check("ws0 write err", 32'(err), 32'h0);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, -1, -1, rd, err, nc);
        check("ws0 read data", rd, 32'hDEADBEEF);
        check("ws0 read cycles", 32'(nc), 32'd2);
        xfer(0, 1'b0, 8'h08, 32'h0, 4'hF, -1, -1, rd, err, nc);
        check("ws0 read 0x08", rd, 32'h0);

        // Three wait states
        xfer(1, 1'b0, 8'h00, 32'h0, 4'hF, -1, -1, rd, err, nc);
        check("ws3 read cycles", 32'(nc), 32'd5);
        check("ws3 read data", rd, 32'h0);

        // Error cases leave registers untouched
        xfer(0, 1'b1, 8'h00, 32'h12345678, 4'hF, -1, -1, rd, err, nc);
        xfer(0, 1'b1, 8'h02, 32'hFFFFFFFF, 4'hF, -1, -1, rd, err, nc);
        check("misaligned err", 32'(err), 32'h1);
        xfer(0, 1'b1, 8'(4*NR), 32'hFFFFFFFF, 4'hF, -1, -1, rd, err, nc);
        check("out of range err", 32'(err), 32'h1);
        xfer(0, 1'b1, 8'h1C, 32'hFFFFFFFF, 4'hF, -1, -1, rd, err, nc);
        check("read-only err", 32'(err), 32'h1);
        xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, -1, -1, rd, err, nc);
        check("reg0 intact", rd, 32'h12345678);
        xfer(0, 1'b0, 8'h1C, 32'h0, 4'hF, -1, -1, rd, err, nc);
        check("read-only read data", rd, 32'h0);
        check("read-only read err", 32'(err), 32'h0);

        // Abort after one access cycle
        xfer(1, 1'b1, 8'h0C, 32'h55, 4'hF, 1, -1, rd, err, nc);
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'hF, -1, -1, rd, err, nc);
        check("abort no write", rd, 32'h0);
        check("abort then idle cycles", 32'(nc), 32'd5);

        // Back-to-back with no idle cycle
        xfer(0, 1'b1, 8'h10, 32'h1, 4'hF, -1, -1, rd, err, nc);
        xfer(0, 1'b0, 8'h10, 32'h0, 4'hF, -1, -1, rd, err, nc2);
        check("b2b read data", rd, 32'h1);
        check("b2b cycles", 32'(nc + nc2), 32'd4);

`ifdef APB_REGFILE_PSTRB_EN
        xfer(0, 1'b1, 8'h00, 32'hAABBCCDD, 4'hF, -1, -1, rd, err, nc);
        xfer(0, 1'b1, 8'h00, 32'h11223344, 4'b0101, -1, -1, rd, err, nc);
        xfer(0, 1'b1, 8'h00, 32'h99999999, 4'b0000, -1, -1, rd, err, nc);
        check("zero strobe err", 32'(err), 32'h0);
        xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, -1, -1, rd, err, nc);
        check("strobe merge", rd, 32'hAA22CC44);
`endif

        // Reset in the middle of an access phase
        xfer(1, 1'b1, 8'h08, 32'h99, 4'hF, -1, 1, rd, err, nc);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, -1, -1, rd, err, nc);
        check("reset clears dut0", rd, 32'h0);
        xfer(1, 1'b0, 8'h08, 32'h0, 4'hF, -1, -1, rd, err, nc);
        check("reset drops write", rd, 32'h0);

        // Randomized traffic checked every cycle against the model
        allow_hold = 1'b1;
        repeat (300) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = 8'(4 * $urandom_range(0, NR));
            if ($urandom_range(0, 3) == 0) a = a | 8'($urandom_range(1, 3));
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, ws_of[d])) : -1;
            xfer(d, wr, a, $urandom, 4'($urandom), ab, -1, rd, err, nc);
            repeat ($urandom_range(0, 2)) begin
                @(posedge PCLK); #1;
            end
        end

        @(posedge PCLK); #1;
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
